// File: rtl/exec_trace_buffer.sv
// Execution-trace capture beside the single-cycle MIPS core: a circular buffer of retired
// instructions, frozen by a selectable trigger plus a programmable post-trigger tail.
module exec_trace_buffer #(
   parameter int PC_WIDTH       = 10,
   parameter int INSTR_WIDTH    = 32,
   parameter int DATA_WIDTH     = 16,
   parameter int REG_ADDR_WIDTH = 4,
   parameter int DEPTH          = 16
) (
   input  logic                        clock,
   input  logic                        reset_n,
   input  logic                        arm,
   input  logic [1:0]                  trig_mode,
   input  logic [PC_WIDTH-1:0]         trig_pc,
   input  logic [$clog2(DEPTH)-1:0]    post_count,
   input  logic                        s_valid,
   input  logic [PC_WIDTH-1:0]         s_pc,
   input  logic [INSTR_WIDTH-1:0]      s_instr,
   input  logic                        s_jump,
   input  logic                        s_jump_reg,
   input  logic                        s_jump_and_link,
   input  logic                        s_branch,
   input  logic                        s_branch_not,
   input  logic                        s_alu_zero,
   input  logic                        s_reg_write,
   input  logic [REG_ADDR_WIDTH-1:0]   s_write_reg,
   input  logic [DATA_WIDTH-1:0]       s_write_back,
   output logic                        armed,
   output logic                        triggered,
   output logic                        done,
   output logic [$clog2(DEPTH):0]      count,
   output logic                        rd_valid,
   input  logic                        rd_ready,
   output logic                        rd_last,
   output logic [PC_WIDTH-1:0]         rd_pc,
   output logic [INSTR_WIDTH-1:0]      rd_instr,
   output logic                        rd_wen,
   output logic [REG_ADDR_WIDTH-1:0]   rd_wreg,
   output logic [DATA_WIDTH-1:0]       rd_wdata
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

   typedef enum logic [1:0] {IDLE, PRE, POST, DONE} state_t;

   state_t                     state;
   logic [PC_WIDTH-1:0]        mem_pc    [DEPTH];
   logic [INSTR_WIDTH-1:0]     mem_instr [DEPTH];
   logic                       mem_wen   [DEPTH];
   logic [REG_ADDR_WIDTH-1:0]  mem_wreg  [DEPTH];
   logic [DATA_WIDTH-1:0]      mem_wdata [DEPTH];

   logic [AW-1:0] wr_ptr, rd_ptr, remaining, post_lat;
   logic [1:0]    mode;
   logic          hit, start, store, finish;
   logic [AW-1:0] wr_next;
   logic [AW:0]   count_inc;

   always_comb begin
      hit = 1'b0;
      case (mode)
         2'b00:   hit = s_jump | s_jump_reg | s_jump_and_link;
         2'b01:   hit = (s_branch & s_alu_zero) | (s_branch_not & ~s_alu_zero);
         2'b10:   hit = (s_pc == trig_pc);
         default: hit = 1'b1;
      endcase
   end

   assign start     = arm && (state == IDLE || state == DONE);
   assign store     = s_valid && (state == PRE || state == POST);
   assign finish    = store && ((state == PRE && hit && post_lat == '0) ||
                                (state == POST && remaining == AW'(1)));
   assign wr_next   = wr_ptr + 1'b1;
   assign count_inc = (count == FULL) ? count : count + 1'b1;

   // Storage carries no reset; the count and rd_valid alone decide what is meaningful.
   always_ff @(posedge clock) begin
      if (store) begin
         mem_pc[wr_ptr]    <= s_pc;
         mem_instr[wr_ptr] <= s_instr;
         mem_wen[wr_ptr]   <= s_reg_write;
         mem_wreg[wr_ptr]  <= s_write_reg;
         mem_wdata[wr_ptr] <= s_write_back;
      end
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state     <= IDLE;
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         remaining <= '0;
         post_lat  <= '0;
         mode      <= 2'b00;
         armed     <= 1'b0;
         triggered <= 1'b0;
         done      <= 1'b0;
         rd_valid  <= 1'b0;
         rd_last   <= 1'b0;
      end else if (start) begin
         state     <= PRE;
         wr_ptr    <= '0;
         count     <= '0;
         post_lat  <= post_count;
         mode      <= trig_mode;
         armed     <= 1'b1;
         triggered <= 1'b0;
         done      <= 1'b0;
         rd_valid  <= 1'b0;
         rd_last   <= 1'b0;
      end else if (store) begin
         wr_ptr <= wr_next;
         count  <= count_inc;
         if (state == PRE && hit)
            triggered <= 1'b1;
         if (state == POST)
            remaining <= remaining - 1'b1;
         // Oldest surviving entry sits count_inc slots behind the next write slot.
         if (finish) begin
            state    <= DONE;
            armed    <= 1'b0;
            done     <= 1'b1;
            rd_valid <= 1'b1;
            rd_ptr   <= wr_next - count_inc[AW-1:0];
            rd_last  <= (count_inc == (AW+1)'(1));
         end else if (state == PRE && hit) begin
            state     <= POST;
            remaining <= post_lat;
         end
      end else if (state == DONE && rd_valid && rd_ready) begin
         rd_ptr  <= rd_ptr + 1'b1;
         count   <= count - 1'b1;
         rd_last <= (count == (AW+1)'(2));
         if (rd_last) begin
            state     <= IDLE;
            done      <= 1'b0;
            rd_valid  <= 1'b0;
            triggered <= 1'b0;
            rd_last   <= 1'b0;
         end
      end
   end

   assign rd_pc    = rd_valid ? mem_pc[rd_ptr]    : '0;
   assign rd_instr = rd_valid ? mem_instr[rd_ptr] : '0;
   assign rd_wen   = rd_valid ? mem_wen[rd_ptr]   : 1'b0;
   assign rd_wreg  = rd_valid ? mem_wreg[rd_ptr]  : '0;
   assign rd_wdata = rd_valid ? mem_wdata[rd_ptr] : '0;

endmodule

// File: tb/tb_exec_trace_buffer.sv
// Bench for exec_trace_buffer (DEPTH=8): a behavioural capture model fills a scoreboard
// queue as samples are driven; readout pops and compares entry by entry.
module tb_exec_trace_buffer;

   localparam int DEPTH = 8;
   localparam int AW    = 3;

   logic          clock = 1'b0;
   logic          reset_n, arm, s_valid, rd_ready;
   logic [1:0]    trig_mode;
   logic [9:0]    trig_pc, s_pc;
   logic [AW-1:0] post_count;
   logic [31:0]   s_instr;
   logic          s_jump, s_jump_reg, s_jump_and_link, s_branch, s_branch_not, s_alu_zero;
   logic          s_reg_write;
   logic [3:0]    s_write_reg;
   logic [15:0]   s_write_back;
   logic          armed, triggered, done, rd_valid, rd_last, rd_wen;
   logic [AW:0]   count;
   logic [9:0]    rd_pc;
   logic [31:0]   rd_instr;
   logic [3:0]    rd_wreg;
   logic [15:0]   rd_wdata;

   typedef struct packed {
      logic [9:0]  pc;
      logic [31:0] instr;
      logic        wen;
      logic [3:0]  wreg;
      logic [15:0] wdata;
   } entry_t;

   entry_t sb[$];
   int     mstate = 0;
   int     mmode = 0, mpost = 0, mrem = 0;
   bit     mtrig = 0;
   int     checkCount = 0, passCount = 0;

   exec_trace_buffer #(.DEPTH(DEPTH)) dut (
      .clock(clock), .reset_n(reset_n), .arm(arm), .trig_mode(trig_mode), .trig_pc(trig_pc),
      .post_count(post_count), .s_valid(s_valid), .s_pc(s_pc), .s_instr(s_instr),
      .s_jump(s_jump), .s_jump_reg(s_jump_reg), .s_jump_and_link(s_jump_and_link),
      .s_branch(s_branch), .s_branch_not(s_branch_not), .s_alu_zero(s_alu_zero),
      .s_reg_write(s_reg_write), .s_write_reg(s_write_reg), .s_write_back(s_write_back),
      .armed(armed), .triggered(triggered), .done(done), .count(count),
      .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_last(rd_last), .rd_pc(rd_pc),
      .rd_instr(rd_instr), .rd_wen(rd_wen), .rd_wreg(rd_wreg), .rd_wdata(rd_wdata)
   );

   always #5 clock = ~clock;

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      checkCount++;
      if (observed === expected) passCount++;
      else $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic checkStatus(input string tag);
      checkOutput({tag, ".armed"}, 64'(armed), 64'(mstate == 1 || mstate == 2));
      checkOutput({tag, ".done"}, 64'(done), 64'(mstate == 3));
      checkOutput({tag, ".rd_valid"}, 64'(rd_valid), 64'(mstate == 3));
      checkOutput({tag, ".triggered"}, 64'(triggered), 64'(mtrig));
      checkOutput({tag, ".count"}, 64'(count), 64'(sb.size()));
   endtask

   task automatic pulseArm(input logic [1:0] m, input logic [AW-1:0] p);
      trig_mode  = m;
      post_count = p;
      arm        = 1'b1;
      if (mstate == 0 || mstate == 3) begin
         mstate = 1; mmode = int'(m); mpost = int'(p); mtrig = 0;
         sb.delete();
      end
      tick();
      arm = 1'b0;
      checkStatus("arm");
   endtask

   // flags = {jump, jump_reg, jal, branch, branch_not, alu_zero}
   task automatic applyStimulus(input logic [9:0] pc, input logic [5:0] flags);
      entry_t e;
      bit     hitv;
      e.pc    = pc;
      e.instr = 32'hA500_0000 ^ {22'd0, pc};
      e.wen   = pc[0];
      e.wreg  = pc[3:0];
      e.wdata = 16'(pc * 7 + 1);
      s_valid = 1'b1; s_pc = e.pc; s_instr = e.instr;
      s_reg_write = e.wen; s_write_reg = e.wreg; s_write_back = e.wdata;
      {s_jump, s_jump_reg, s_jump_and_link, s_branch, s_branch_not, s_alu_zero} = flags;
      if (mstate == 1 || mstate == 2) begin
         sb.push_back(e);
         if (sb.size() > DEPTH) void'(sb.pop_front());
         if (mstate == 1) begin
            case (mmode)
               0: hitv = flags[5] | flags[4] | flags[3];
               1: hitv = (flags[2] & flags[0]) | (flags[1] & ~flags[0]);
               2: hitv = (pc == trig_pc);
               default: hitv = 1;
            endcase
            if (hitv) begin
               mtrig = 1;
               if (mpost == 0) mstate = 3;
               else begin mstate = 2; mrem = mpost; end
            end
         end else begin
            mrem--;
            if (mrem == 0) mstate = 3;
         end
      end
      tick();
      s_valid = 1'b0;
      {s_jump, s_jump_reg, s_jump_and_link, s_branch, s_branch_not, s_alu_zero} = 6'd0;
      checkStatus("sample");
   endtask

   task automatic drainAndCheck(input int maxReads, input bit toggleReady);
      int  reads = 0;
      int  cyc   = 0;
      bit  took;
      while (sb.size() > 0 && reads < maxReads && cyc < 64) begin
         checkOutput("rd_valid", 64'(rd_valid), 64'd1);
         checkOutput("rd_count", 64'(count), 64'(sb.size()));
         if (rd_valid) begin
            checkOutput("rd_pc", 64'(rd_pc), 64'(sb[0].pc));
            checkOutput("rd_instr", 64'(rd_instr), 64'(sb[0].instr));
            checkOutput("rd_wb", 64'({rd_wen, rd_wreg, rd_wdata}), 64'({sb[0].wen, sb[0].wreg, sb[0].wdata}));
            checkOutput("rd_last", 64'(rd_last), 64'(sb.size() == 1));
         end
         rd_ready = toggleReady ? cyc[0] == 1'b0 : 1'b1;
         took = rd_valid && rd_ready;
         tick();
         cyc++;
         if (took) begin
            void'(sb.pop_front());
            reads++;
            if (sb.size() == 0) begin mstate = 0; mtrig = 0; end
         end
      end
      rd_ready = 1'b0;
      if (cyc >= 64) checkOutput("drain_timeout", 64'd1, 64'd0);
      checkStatus("drain");
   endtask

   initial begin
      reset_n = 1'b0; arm = 1'b0; s_valid = 1'b1; rd_ready = 1'b0;
      trig_mode = 2'b00; trig_pc = '0; post_count = '0;
      s_pc = '0; s_instr = '0; s_reg_write = 1'b0; s_write_reg = '0; s_write_back = '0;
      {s_jump, s_jump_reg, s_jump_and_link, s_branch, s_branch_not, s_alu_zero} = 6'd0;

      tick();
      arm = 1'b1;
      tick();
      arm = 1'b0;
      tick();
      checkStatus("reset");
      reset_n = 1'b1;
      s_valid = 1'b0;
      tick();
      checkStatus("post_reset");

      $display("[TB] mode 00 any jump, post_count=2");
      pulseArm(2'b00, 3'd2);
      for (int i = 0; i < 12; i++) applyStimulus(10'(i), (i == 9) ? 6'b100000 : 6'd0);
      applyStimulus(10'd12, 6'b100000);
      drainAndCheck(100, 1'b0);

      $display("[TB] mode 01 taken branch, post_count=0");
      pulseArm(2'b01, 3'd0);
      for (int i = 0; i < 7; i++)
         applyStimulus(10'(i), (i == 3) ? 6'b000100 : (i == 6) ? 6'b000010 : 6'd0);
      drainAndCheck(100, 1'b0);

      $display("[TB] mode 10 pc match with gaps and stalled readout");
      trig_pc = 10'h2A;
      pulseArm(2'b10, 3'd3);
      for (int i = 'h20; i < 'h30; i++) begin
         applyStimulus(10'(i), 6'b000001);
         if (i[0]) tick();
      end
      drainAndCheck(100, 1'b1);

      $display("[TB] re-arm in DONE, arm ignored in POST");
      pulseArm(2'b11, 3'd4);
      applyStimulus(10'h100, 6'd0);
      pulseArm(2'b00, 3'd0);
      for (int i = 1; i < 5; i++) applyStimulus(10'(10'h100 + i), 6'd0);
      drainAndCheck(2, 1'b0);
      pulseArm(2'b11, 3'd1);
      applyStimulus(10'h200, 6'd0);
      applyStimulus(10'h201, 6'd0);
      drainAndCheck(100, 1'b0);

      $display("[TB] reset during POST");
      pulseArm(2'b11, 3'd5);
      for (int i = 0; i < 3; i++) applyStimulus(10'(10'h300 + i), 6'd0);
      reset_n = 1'b0;
      mstate = 0; mtrig = 0; sb.delete();
      tick();
      reset_n = 1'b1;
      checkStatus("mid_reset");
      for (int i = 3; i < 6; i++) applyStimulus(10'(10'h300 + i), 6'd0);

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule

// File: doc/exec_trace_buffer.md
# exec_trace_buffer

Hardware execution-trace capture for the single-cycle MIPS core: a parametrised circular buffer recording one entry per retired instruction (PC, instruction, register write-back), frozen by a configurable trigger (any jump, taken branch, PC match, immediate) with programmable post-trigger depth. It sits beside `single_cycle_mips`, fed from its datapath/control nets, and drains captured history through a valid/ready read port, replacing cycle-by-cycle simulator monitoring with a synthesisable probe usable on silicon and in benches alike.

## Interface
- `PC_WIDTH`, 10, program-counter width
- `INSTR_WIDTH`, 32, instruction width
- `DATA_WIDTH`, 16, write-back data width
- `REG_ADDR_WIDTH`, 4, register-address width
- `DEPTH`, 16, buffer entries; power of two, >= 4; `AW` = log2(DEPTH)

- `clock`  in  1  rising-edge clock, shared with the core
- `reset_n`  in  1  synchronous, active-low reset
- `arm`  in  1  start capture (single-cycle pulse)
- `trig_mode`  in  2  00 any jump, 01 taken branch, 10 PC match, 11 immediate
- `trig_pc`  in  PC_WIDTH  match value for mode 10
- `post_count`  in  AW  samples stored after the trigger sample; sampled on `arm`
- `s_valid`  in  1  one instruction retired this cycle
- `s_pc`, `s_instr`  in  PC_WIDTH / INSTR_WIDTH  retiring PC and instruction
- `s_jump`, `s_jump_reg`, `s_jump_and_link`, `s_branch`, `s_branch_not`, `s_alu_zero`  in  1 each  core control flags
- `s_reg_write`  in  1; `s_write_reg`  in  REG_ADDR_WIDTH; `s_write_back`  in  DATA_WIDTH  write-back info
- `armed`, `triggered`, `done`  out  1  status
- `count`  out  AW+1  valid entries held (0..DEPTH)
- `rd_valid`  out 1; `rd_ready`  in 1; `rd_last`  out 1  read handshake
- `rd_pc`, `rd_instr`, `rd_wen`, `rd_wreg`, `rd_wdata`  out  entry fields

## Operation
- States: IDLE, PRE, POST, DONE. Reset -> IDLE; all outputs 0, pointers/count 0.
- IDLE: samples ignored. `arm` -> PRE; clear `count`, latch `post_count` and `trig_mode`.
- PRE: each `s_valid` writes entry at `wr_ptr`, `wr_ptr` += 1 mod DEPTH, `count` saturates at DEPTH (oldest overwritten). Trigger evaluated on that same sample:
  - 00: `s_jump | s_jump_reg | s_jump_and_link`
  - 01: `(s_branch & s_alu_zero) | (s_branch_not & ~s_alu_zero)`
  - 10: `s_pc == trig_pc`
  - 11: first valid sample after `arm`
- Trigger sample is stored; latched post_count 0 -> DONE, else -> POST with `remaining` = post_count.
- POST: each valid sample stored, `remaining` -= 1; write that takes it to 0 -> DONE.
- DONE: no writes. Read pointer starts at oldest entry (`wr_ptr - count` mod DEPTH). Transfer on `rd_valid & rd_ready`; pointer advances, `count` -= 1; `rd_last` = (`count` == 1). Transfer with `rd_last` -> IDLE.
- `arm` in PRE/POST ignored. `arm` in DONE discards unread entries, restarts as from IDLE.
- `s_valid` low: no write, no trigger evaluation, no decrement.

## Timing
- All outputs registered except `rd_*` fields, combinational from the storage array at read pointer.
- `armed` = 1 in PRE/POST, rises the cycle after `arm`.
- `triggered` rises the cycle after the trigger sample's edge; stays until IDLE/re-arm.
- `done`/`rd_valid` rise the cycle after the final stored sample; `rd_*` stable while `rd_valid & ~rd_ready`.
- Readout: one entry per cycle at `rd_ready` = 1.
- Trigger capture latency zero: trigger sample always in buffer. Retained pre-trigger samples = min(pre samples seen, DEPTH-1-post_count).
- Reset mid-operation: IDLE at that edge, buffer contents invalidated.

## Test plan
- Reset: `reset_n`=0 for 3 cycles with `s_valid`=1, `arm` pulsed -> `armed`=`done`=`rd_valid`=0, `count`=0.
- DEPTH=8, mode 00, post_count=2: PCs 0..11 with `s_jump`=1 at PC 9 -> `done` after PC 11; readout PCs 4..11, `rd_last` on PC 11, then IDLE.
- Mode 01, post_count=0: `s_branch`=1,`s_alu_zero`=0 at PC 3 (no trigger); `s_branch_not`=1,`s_alu_zero`=0 at PC 6 -> `count`=7, readout PCs 0..6.
- Mode 10, `trig_pc`=0x2A, `s_valid` gaps, `rd_ready` toggled 1/0 -> every entry transferred once, in order, stable during stalls; `rd_wen/rd_wreg/rd_wdata` match inputs.
- Re-arm in DONE after 2 of 5 reads -> `count`=0, `rd_valid`=0 next cycle, new mode-11 capture stores first sample as trigger; `arm` during POST has no effect.
- `reset_n`=0 during POST with `remaining`=3 -> IDLE, `armed`=`triggered`=0 next cycle, no `done`.
